// File: rtl/gcd_link_pkg.sv
// rtl/gcd_link_pkg.sv - shared states and segment glyphs for the GCD target link
// Contents:
//   state_e     sender sequencing states
//   SEG_*       progress glyphs shown by the target (gfedcba, bit0 = a, active-high)
//   HEX_GLYPH   16-entry hex digit glyph table, index = digit value
package gcd_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    OK1,
    GAP1,
    OK2,
    GAP2,
    WAIT,
    CAP
  } state_e;

  localparam logic [6:0] SEG_IDLE = 7'h40;
  localparam logic [6:0] SEG_OKEY = 7'h5C;
  localparam logic [6:0] SEG_NEXT = 7'h54;

  // Packed with digit F in the top slot so HEX_GLYPH[d] is the glyph for d.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/ssd_to_hex.sv
// rtl/ssd_to_hex.sv - inverse seven-segment decoder, glyph to hex digit
// Ports:
//   seg_i    in   7  segment bus, gfedcba, active-high
//   digit_o  out  4  decoded digit (0 when no match)
//   hit_o    out  1  seg_i matches one of the 16 hex glyphs
module ssd_to_hex
  import gcd_link_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       hit_o
);

  // The 16 glyphs are distinct, so at most one entry can match.
  always_comb begin
    digit_o = '0;
    hit_o   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == HEX_GLYPH[i]) begin
        digit_o = 4'(i);
        hit_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_operand_sender.sv
// rtl/gcd_operand_sender.sv - drives the two-step number/num_okey entry into a GCD target and reads back the result
// Ports:
//   clk_i       in   1          clock
//   rst_i       in   1          synchronous active-high reset
//   start_i     in   1          request, accepted when start_i && ready_o
//   x_i, y_i    in   DATA_BITS  operands, sampled on accept
//   ready_o     out  1          high only in IDLE
//   tgt_rst_o   out  1          target reset pin
//   num_okey_o  out  1          target num_okey pin
//   number_o    out  DATA_BITS  target number pins
//   ssd_i       in   7          target segment bus, gfedcba, active-high
//   result_o    out  DATA_BITS  decoded GCD, held until the next done
//   done_o      out  1          one-cycle completion pulse
//   err_o       out  1          valid with done_o; glyph mismatch or undecodable result
module gcd_operand_sender
  import gcd_link_pkg::*;
#(
  parameter int DATA_BITS     = 4,
  parameter int RST_CYCLES    = 2,
  parameter int HOLD_CYCLES   = 4,
  parameter int GAP_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] x_i,
  input  logic [DATA_BITS-1:0] y_i,
  output logic                 ready_o,
  output logic                 tgt_rst_o,
  output logic                 num_okey_o,
  output logic [DATA_BITS-1:0] number_o,
  input  logic [6:0]           ssd_i,
  output logic [DATA_BITS-1:0] result_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int MAX_AB  = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
  localparam int MAX_CD  = (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

  state_e               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [DATA_BITS-1:0] x_q, y_q;
  logic                 err_flag, err_flag_d;

  logic                 tgt_rst_d, num_okey_d, ready_d, done_d, err_d;
  logic [DATA_BITS-1:0] number_d, result_d;

  logic                 last, accept, glyph_bad;
  logic [3:0]           cap_digit;
  logic                 cap_hit;

  ssd_to_hex u_ssd_to_hex (
    .seg_i   (ssd_i),
    .digit_o (cap_digit),
    .hit_o   (cap_hit)
  );

  // Phase counters count down from N-1; the phase ends on the cycle cnt is 0.
  function automatic logic [CNT_W-1:0] phase_len(input state_e s);
    case (s)
      RST:      phase_len = CNT_W'(RST_CYCLES - 1);
      OK1, OK2: phase_len = CNT_W'(HOLD_CYCLES - 1);
      GAP1, GAP2: phase_len = CNT_W'(GAP_CYCLES - 1);
      WAIT:     phase_len = CNT_W'(SETTLE_CYCLES - 1);
      default:  phase_len = '0;
    endcase
  endfunction

  assign last   = (cnt == '0);
  assign accept = start_i && ready_o;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RST;
      RST:     if (last)   state_d = OK1;
      OK1:     if (last)   state_d = GAP1;
      GAP1:    if (last)   state_d = OK2;
      OK2:     if (last)   state_d = GAP2;
      GAP2:    if (last)   state_d = WAIT;
      WAIT:    if (last)   state_d = CAP;
      CAP:                 state_d = IDLE;
      default:             state_d = IDLE;
    endcase

    if (state_d != state)
      cnt_d = phase_len(state_d);
    else if (!last)
      cnt_d = cnt - 1'b1;
    else
      cnt_d = cnt;
  end

  // Progress glyphs are only checked on the final cycle of a phase, after the
  // target has had the whole phase to react.
  assign glyph_bad = last && ((((state == OK1) || (state == OK2)) && (ssd_i != SEG_OKEY)) ||
                              ((state == GAP1) && (ssd_i != SEG_NEXT)));

  // Output logic: next values of the registered outputs, aligned to state_d so
  // every pin changes together with the phase it belongs to.
  always_comb begin
    ready_d    = (state_d == IDLE);
    tgt_rst_d  = (state_d == RST);
    num_okey_d = (state_d == OK1) || (state_d == OK2);

    // number stays on the operand through the gap; the target latches it on
    // the first okey-low cycle.
    case (state_d)
      OK1, GAP1:            number_d = x_q;
      OK2, GAP2, WAIT, CAP: number_d = y_q;
      default:              number_d = '0;
    endcase

    err_flag_d = err_flag;
    if (accept)
      err_flag_d = 1'b0;
    else if (glyph_bad)
      err_flag_d = 1'b1;

    done_d   = (state == CAP);
    err_d    = (state == CAP) && (err_flag || !cap_hit);
    result_d = result_o;
    if (state == CAP)
      result_d = cap_hit ? DATA_BITS'(cap_digit) : '0;
  end

  // Output and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_o    <= 1'b1;
      tgt_rst_o  <= 1'b0;
      num_okey_o <= 1'b0;
      number_o   <= '0;
      result_o   <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_flag   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      ready_o    <= ready_d;
      tgt_rst_o  <= tgt_rst_d;
      num_okey_o <= num_okey_d;
      number_o   <= number_d;
      result_o   <= result_d;
      done_o     <= done_d;
      err_o      <= err_d;
      err_flag   <= err_flag_d;
      if (accept) begin
        x_q <= x_i;
        y_q <= y_i;
      end
    end
  end

endmodule

// File: doc/gcd_operand_sender.md
Name: gcd_operand_sender

Overview:
Host-side initiator for the switch-entry GCD front end. Takes two 4-bit operands on a valid/ready handshake and resets the target. It then plays the two-step number/num_okey entry sequence onto the target's pins. It watches the target's seven-segment output for the expected progress glyphs, then decodes the final glyph back to a 4-bit GCD result. Used as an on-chip self-test driver and as the bench-side stimulus block.

Parameters:
DATA_BITS, 4, operand/result width
RST_CYCLES, 2, cycles tgt_rst_o held high per transaction (>=1)
HOLD_CYCLES, 4, cycles num_okey_o held high per operand (>=3)
GAP_CYCLES, 4, cycles num_okey_o held low after each operand (>=3)
SETTLE_CYCLES, 32, cycles waited after second operand before sampling result (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  request; accepted when start_i && ready_o at a rising edge
x_i  in  DATA_BITS  first operand, sampled on accept
y_i  in  DATA_BITS  second operand, sampled on accept
ready_o  out  1  high only in IDLE
tgt_rst_o  out  1  drives target reset pin
num_okey_o  out  1  drives target num_okey pin
number_o  out  DATA_BITS  drives target number pins
ssd_i  in  7  target segment bus, gfedcba, bit0=a, active-high
result_o  out  DATA_BITS  decoded GCD, held until next done
done_o  out  1  one-cycle pulse, transaction complete
err_o  out  1  valid with done_o; any glyph mismatch or undecodable result

Behaviour:
- Reset (rst_i=1 at edge): state IDLE; ready_o=1; tgt_rst_o=0, num_okey_o=0, number_o=0, result_o=0, done_o=0, err_o=0. Reset mid-transaction aborts immediately; no partial done.
- All outputs registered; counters load (N-1) on phase entry and advance at 0.
- IDLE: on accept, latch x,y, clear the internal error flag, go RST.
- RST: tgt_rst_o=1, num_okey_o=0, number_o=0 for RST_CYCLES, then OK1.
- OK1: number_o=x, num_okey_o=1 for HOLD_CYCLES. On the last cycle, require ssd_i==SEG_OKEY (0x5C), else set the error flag. Then GAP1.
- GAP1: num_okey_o=0, number_o stays x (the target latches on the okey-low cycle) for GAP_CYCLES. On the last cycle, require ssd_i==SEG_NEXT (0x54). Then OK2.
- OK2: number_o=y, num_okey_o=1 for HOLD_CYCLES. On the last cycle, require SEG_OKEY. Then GAP2.
- GAP2: num_okey_o=0, number_o stays y for GAP_CYCLES; no check. Then WAIT.
- WAIT: SETTLE_CYCLES cycles, then CAP.
- CAP (one cycle): decode ssd_i through the hex table.
  - Hit: result_o=digit.
  - Miss (including idle glyph 0x40): result_o=0 and set the error.
  - done_o=1, err_o=error flag. Next state IDLE.
  - done_o and err_o clear the following cycle; result_o holds.
- Latency: done_o is high exactly RST_CYCLES+2*HOLD_CYCLES+2*GAP_CYCLES+SETTLE_CYCLES+1 cycles after the accept edge. Defaults: 2+8+8+32+1 = 51.
- start_i while not ready is ignored, not queued. The next accept is possible on the cycle after done_o.
- tgt_rst_o is low outside RST. The target stays in its result state until the next transaction's RST phase.
- Hex table (gfedcba):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71

Decomposition:
- Package gcd_link_pkg:
  - state enum IDLE, RST, OK1, GAP1, OK2, GAP2, WAIT, CAP
  - glyph constants SEG_IDLE=7'h40, SEG_OKEY=7'h5C, SEG_NEXT=7'h54
  - the 16-entry hex glyph table
- One sub-module: ssd_to_hex. Combinational 7-bit glyph in, 4-bit digit plus hit out; inverse of the target's segment decoder.

Test Plan:
- x=12, y=8 against the real target with default parameters -> done_o at accept+51, result_o=4, err_o=0, ssd_i=0x66 at CAP.
- Back-to-back x=15,y=5 then x=7,y=7, start_i held high -> results 5 then 7, err_o=0; the second accept lands the cycle after the first done_o; tgt_rst_o pulses once per transaction.
- Behavioural target with ssd_i stuck at 0x40 -> done_o at accept+51, err_o=1, result_o=0.
- Target that shows 0x5C in GAP1 instead of 0x54, correct final 0x4F -> result_o=3, err_o=1.
- rst_i asserted for one cycle during OK2 -> next cycle ready_o=1, num_okey_o=0, number_o=0, tgt_rst_o=0; no done_o; a fresh transaction then completes normally.
- start_i pulsed during WAIT with different operands -> ignored; result and done timing match the original operands only.
